vram_fill_ctrl: RTL and testbench

//   Owns the write port of the 256K x 4-bit hi-res video memory and shares it between two requesters:
//   - CPU nibble writes, decoded from the port $20 data-port logic.
//   - A hardware rectangle-fill engine, started by the CPU.
//   CPU writes always win. The fill engine steps one pixel per free cycle, so clearing the screen
//   no longer costs 256000 CPU port writes. The block sits between the port decoder and mem_hivid port 1.

---
 rtl/vram_fill_ctrl.sv | 120 ++++++++++++
 tb/tb_vram_fill_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill_ctrl.sv
// Write-port arbiter for the hi-res video memory: CPU nibble writes always win,
// and a rectangle-fill engine uses every cycle the CPU leaves free.
module vram_fill_ctrl #(
    parameter int AW    = 18,
    parameter int DW    = 4,
    parameter int PITCH = 640,
    parameter int WW    = 10,
    parameter int HW    = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_data,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [WW-1:0] fill_w,
    input  logic [HW-1:0] fill_h,
    input  logic [DW-1:0] fill_color,
    input  logic          fill_abort,
    output logic          busy,
    output logic          done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [AW-1:0] PITCH_A = AW'(PITCH);

    state_t        state;
    logic [WW-1:0] w_q;
    logic [HW-1:0] h_q;
    logic [DW-1:0] color_q;
    logic [AW-1:0] row_addr;
    logic [AW-1:0] cur;
    logic [WW-1:0] col;
    logic [HW-1:0] row;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            row_addr <= '0;
            cur      <= '0;
            col      <= '0;
            row      <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;

            // CPU write takes the port in every state; fill only sees leftover cycles.
            if (cpu_we) begin
                mem_we   <= 1'b1;
                mem_addr <= cpu_addr;
                mem_data <= cpu_data;
            end

            case (state)
                IDLE: begin
                    if (fill_start && !fill_abort) begin
                        w_q      <= fill_w;
                        h_q      <= fill_h;
                        color_q  <= fill_color;
                        row_addr <= fill_base;
                        cur      <= fill_base;
                        col      <= '0;
                        row      <= '0;
                        if (fill_w == '0 || fill_h == '0) begin
                            state <= DONE;
                        end else begin
                            state <= FILL;
                            busy  <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    if (fill_abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!cpu_we) begin
                        mem_we   <= 1'b1;
                        mem_addr <= cur;
                        mem_data <= color_q;
                        if (col == w_q - WW'(1)) begin
                            if (row == h_q - HW'(1)) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                            col      <= '0;
                            row      <= row + HW'(1);
                            row_addr <= row_addr + PITCH_A;
                            cur      <= row_addr + PITCH_A;
                        end else begin
                            col <= col + WW'(1);
                            cur <= cur + AW'(1);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// Directed bench for vram_fill_ctrl: each task drives one scenario and checks
// the registered memory port, busy and done cycle by cycle against hand-computed values.
module tb_vram_fill_ctrl;

    logic        clock;
    logic        reset;
    logic        cpu_we;
    logic [17:0] cpu_addr;
    logic [3:0]  cpu_data;
    logic        fill_start;
    logic [17:0] fill_base;
    logic [9:0]  fill_w;
    logic [8:0]  fill_h;
    logic [3:0]  fill_color;
    logic        fill_abort;
    logic        busy;
    logic        done;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [3:0]  mem_data;

    int n_cmp = 0;
    int n_bad = 0;

    vram_fill_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .fill_abort (fill_abort),
        .busy       (busy),
        .done       (done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    // Advance one cycle; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        fill_start = 1'b0;
        fill_abort = 1'b0;
        cpu_we     = 1'b0;
    endtask

    task automatic start_fill(input logic [17:0] b, input logic [9:0] w,
                              input logic [8:0] h, input logic [3:0] c);
        fill_start = 1'b1;
        fill_base  = b;
        fill_w     = w;
        fill_h     = h;
        fill_color = c;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_fill(18'h00010, 10'd3, 9'd2, 4'hA);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            n_cmp++;
            if (busy !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d busy=%b mem_we=%b done=%b want 0/0/0", k, busy, mem_we, done);
            end
            n_cmp++;
            if (mem_addr !== 18'h0 || mem_data !== 4'h0) begin
                n_bad++;
                $display("FAIL reset_port cyc=%0d addr=%h data=%h want 0/0", k, mem_addr, mem_data);
            end
        end
        reset      = 1'b0;
        fill_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (busy !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset cyc=%0d busy=%b mem_we=%b done=%b want 0/0/0", k, busy, mem_we, done);
            end
        end
    endtask

    task automatic test_basic_fill();
        logic [17:0] ea [6] = '{18'h10, 18'h11, 18'h12, 18'h290, 18'h291, 18'h292};
        start_fill(18'h00010, 10'd3, 9'd2, 4'hA);
        for (int k = 1; k <= 9; k++) begin
            step();
            n_cmp++;
            if (mem_we !== (k >= 2 && k <= 7)) begin
                n_bad++;
                $display("FAIL basic_we k=%0d got=%b want=%b", k, mem_we, (k >= 2 && k <= 7));
            end
            if (k >= 2 && k <= 7) begin
                n_cmp++;
                if (mem_addr !== ea[k-2] || mem_data !== 4'hA) begin
                    n_bad++;
                    $display("FAIL basic_wr k=%0d got=%h/%h want=%h/a", k, mem_addr, mem_data, ea[k-2]);
                end
            end
            n_cmp++;
            if (done !== (k == 8) || busy !== (k <= 6)) begin
                n_bad++;
                $display("FAIL basic_flags k=%0d done=%b busy=%b want %b/%b", k, done, busy, (k == 8), (k <= 6));
            end
        end
    endtask

    task automatic test_cpu_contention();
        logic [17:0] ea [7] = '{18'h10, 18'h3FFFF, 18'h11, 18'h12, 18'h290, 18'h291, 18'h292};
        logic [3:0]  ed [7] = '{4'hA, 4'h5, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
        start_fill(18'h00010, 10'd3, 9'd2, 4'hA);
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++;
            if (mem_we !== (k >= 2 && k <= 8)) begin
                n_bad++;
                $display("FAIL cpu_we k=%0d got=%b want=%b", k, mem_we, (k >= 2 && k <= 8));
            end
            if (k >= 2 && k <= 8) begin
                n_cmp++;
                if (mem_addr !== ea[k-2] || mem_data !== ed[k-2]) begin
                    n_bad++;
                    $display("FAIL cpu_wr k=%0d got=%h/%h want=%h/%h", k, mem_addr, mem_data, ea[k-2], ed[k-2]);
                end
            end
            n_cmp++;
            if (done !== (k == 9) || busy !== (k <= 7)) begin
                n_bad++;
                $display("FAIL cpu_flags k=%0d done=%b busy=%b want %b/%b", k, done, busy, (k == 9), (k <= 7));
            end
            if (k == 2) begin
                cpu_we   = 1'b1;
                cpu_addr = 18'h3FFFF;
                cpu_data = 4'h5;
            end
        end
    endtask

    task automatic test_abort();
        start_fill(18'h00000, 10'd640, 9'd400, 4'h5);
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if (mem_we !== (k >= 2 && k <= 6)) begin
                n_bad++;
                $display("FAIL abort_we k=%0d got=%b want=%b", k, mem_we, (k >= 2 && k <= 6));
            end
            if (k >= 2 && k <= 5) begin
                n_cmp++;
                if (mem_addr !== 18'(k - 2) || mem_data !== 4'h5) begin
                    n_bad++;
                    $display("FAIL abort_wr k=%0d got=%h/%h want=%h/5", k, mem_addr, mem_data, k - 2);
                end
            end
            if (k == 6) begin
                n_cmp++;
                if (mem_addr !== 18'h12345 || mem_data !== 4'h7) begin
                    n_bad++;
                    $display("FAIL abort_cpu got=%h/%h want=12345/7", mem_addr, mem_data);
                end
            end
            n_cmp++;
            if (done !== 1'b0 || busy !== (k <= 5)) begin
                n_bad++;
                $display("FAIL abort_flags k=%0d done=%b busy=%b want 0/%b", k, done, busy, (k <= 5));
            end
            if (k == 5) begin
                fill_abort = 1'b1;
                cpu_we     = 1'b1;
                cpu_addr   = 18'h12345;
                cpu_data   = 4'h7;
            end
        end
        start_fill(18'h00100, 10'd2, 9'd1, 4'h3);
        for (int k = 1; k <= 5; k++) begin
            step();
            n_cmp++;
            if (mem_we !== (k == 2 || k == 3)) begin
                n_bad++;
                $display("FAIL restart_we k=%0d got=%b", k, mem_we);
            end
            if (k == 2 || k == 3) begin
                n_cmp++;
                if (mem_addr !== 18'h100 + 18'(k - 2) || mem_data !== 4'h3) begin
                    n_bad++;
                    $display("FAIL restart_wr k=%0d got=%h/%h want=%h/3", k, mem_addr, mem_data, 18'h100 + 18'(k - 2));
                end
            end
            n_cmp++;
            if (done !== (k == 4) || busy !== (k <= 2)) begin
                n_bad++;
                $display("FAIL restart_flags k=%0d done=%b busy=%b want %b/%b", k, done, busy, (k == 4), (k <= 2));
            end
        end
    endtask

    task automatic test_empty_and_ignore();
        logic [17:0] ea [4] = '{18'h20, 18'h21, 18'h2A0, 18'h2A1};
        start_fill(18'h00040, 10'd0, 9'd5, 4'h2);
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++;
            if (mem_we !== 1'b0 || busy !== 1'b0 || done !== (k == 2)) begin
                n_bad++;
                $display("FAIL empty k=%0d we=%b busy=%b done=%b want 0/0/%b", k, mem_we, busy, done, (k == 2));
            end
        end
        start_fill(18'h00020, 10'd2, 9'd2, 4'h1);
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (mem_we !== (k >= 2 && k <= 5)) begin
                n_bad++;
                $display("FAIL ignore_we k=%0d got=%b", k, mem_we);
            end
            if (k >= 2 && k <= 5) begin
                n_cmp++;
                if (mem_addr !== ea[k-2] || mem_data !== 4'h1) begin
                    n_bad++;
                    $display("FAIL ignore_wr k=%0d got=%h/%h want=%h/1", k, mem_addr, mem_data, ea[k-2]);
                end
            end
            n_cmp++;
            if (done !== (k == 6) || busy !== (k <= 4)) begin
                n_bad++;
                $display("FAIL ignore_flags k=%0d done=%b busy=%b want %b/%b", k, done, busy, (k == 6), (k <= 4));
            end
            if (k == 1 || k == 5) start_fill(18'h00300, 10'd1, 9'd1, 4'hF);
        end
    endtask

    task automatic test_wrap();
        logic [17:0] ea [4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
        start_fill(18'h3FFFE, 10'd4, 9'd1, 4'h6);
        for (int k = 1; k <= 7; k++) begin
            step();
            n_cmp++;
            if (mem_we !== (k >= 2 && k <= 5)) begin
                n_bad++;
                $display("FAIL wrap_we k=%0d got=%b", k, mem_we);
            end
            if (k >= 2 && k <= 5) begin
                n_cmp++;
                if (mem_addr !== ea[k-2] || mem_data !== 4'h6) begin
                    n_bad++;
                    $display("FAIL wrap_wr k=%0d got=%h/%h want=%h/6", k, mem_addr, mem_data, ea[k-2]);
                end
            end
            n_cmp++;
            if (done !== (k == 6) || busy !== (k <= 4)) begin
                n_bad++;
                $display("FAIL wrap_flags k=%0d done=%b busy=%b want %b/%b", k, done, busy, (k == 6), (k <= 4));
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        start_fill(18'h00000, 10'd640, 9'd400, 4'h9);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        n_cmp++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 18'h0) begin
            n_bad++;
            $display("FAIL mid_reset we=%b busy=%b done=%b addr=%h want 0/0/0/0", mem_we, busy, done, mem_addr);
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++;
            if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL after_mid_reset cyc=%0d we=%b busy=%b done=%b want 0/0/0", k, mem_we, busy, done);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_data   = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_w     = '0;
        fill_h     = '0;
        fill_color = '0;
        fill_abort = 1'b0;
        test_reset();
        test_basic_fill();
        test_cpu_contention();
        test_abort();
        test_empty_and_ignore();
        test_wrap();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
